cpu: RTL and testbench
======================

Name: cpu

Overview:
- Single-cycle RV32I-subset processor with internal instruction ROM and data RAM; one instruction completes per clk rising edge.
- Top-level simulation DUT: the bench preloads both memories through hierarchical paths and watches `done`.
- `done` rises when the fetched instruction is 0x00000033 (add x0,x0,x0), marking program end.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth in 32-bit words.
- DMEM_WORDS, 64, data RAM depth in 32-bit words.
- RESET_PC, 32'h0000_0000, PC value while and after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- done  output  1  high while the current instruction equals 32'h0000_0033.

Behaviour:
- Required internal hierarchy, because the bench reaches these by name:
  - instance IMemory containing array ROM[0:IMEM_WORDS-1] of 32 bits;
  - instance DataMemory containing array RAM[0:DMEM_WORDS-1] of 32 bits, with address port a (32b) and write-data port wd (32b);
  - top-level signals outPC (32b current PC) and MemWrite (1b data-store enable).
- Memories have no reset and no initial contents; the bench loads them with $readmemh.
- Reset (rst_n low, asynchronous):
  - outPC = RESET_PC immediately;
  - all 31 registers x1..x31 = 0;
  - done follows ROM[RESET_PC>>2] combinationally.
- Fetch: instr = ROM[outPC[31:2]], combinational. Index wraps modulo IMEM_WORDS; PC bits [1:0] are ignored.
- Register file:
  - 32x32, two asynchronous read ports, one write port on the rising edge;
  - x0 always reads 0 and writes to it are discarded.
- Supported instructions:
  - R-type (opcode 0110011): add, sub, and, or, xor, slt, sltu, sll, srl, sra.
  - I-type ALU (0010011): addi, andi, ori, xori, slti, sltiu, slli, srli, srai.
  - lw (0000011, funct3 010).
  - sw (0100011, funct3 010).
  - beq, bne (1100011).
  - jal (1101111) and jalr (1100111), both writing rd = PC+4.
  - lui (0110111) and auipc (0010111).
- Arithmetic: 32-bit wrap-around. Immediates are sign-extended per RISC-V encoding. Shift amount is operand[4:0].
- Data memory:
  - address a = rs1 + imm;
  - word index a[31:2] modulo DMEM_WORDS;
  - asynchronous read;
  - write wd = rs2 on the rising edge when MemWrite=1;
  - MemWrite is high only for sw.
- Next PC:
  - PC+4 by default;
  - PC+immB when a branch is taken;
  - PC+immJ for jal;
  - (rs1+immI) & ~1 for jalr.
- done=1: PC holds its value, register and memory writes are suppressed, and done stays high until reset.
- Unsupported or illegal opcode or funct: executes as NOP (PC+4, no writes). No trap.
- Load-use in the same cycle is not a hazard (single cycle). A store then a load at the same address in the next cycle returns the new data.
- Deasserting rst_n between edges: the first update happens at the next rising edge. Asserting reset mid-program discards the current instruction's writes.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - alu_op_t enum;
  - DONE_INSTR = 32'h0000_0033.
- Sub-modules:
  - imem (instance IMemory), read-only ROM;
  - dmem (instance DataMemory), synchronous-write RAM;
  - regfile, the register file;
  - an ALU and the decoder, kept inline in cpu.

Test Plan:
- ROM[0]=0x00000033, release reset -> done=1 in the first cycle, outPC stays 0, MemWrite never 1.
- addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sw x3,8(x0); end -> MemWrite pulse with a=8, wd=12 (decimal); RAM[2]=12; done at outPC=0x10.
- RAM[1]=0xFFFF_FFF0 preloaded; lw x4,4(x0); sub x5,x0,x4; sw x5,0(x0) -> RAM[0]=0x10.
- beq x0,x0,+8 skipping a sw -> outPC goes 0,8 and the skipped store never asserts MemWrite. bne x0,x0 is not taken.
- jal x1,+12 at PC 0 -> outPC=0x0C, x1=4. jalr x0,0(x1) -> outPC=4.
- Pull rst_n low mid-program (async, between edges) -> outPC=0 immediately, registers cleared, program re-executes from 0 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the single-cycle RV32I-subset core.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // add x0,x0,x0 marks the end of a program
  localparam logic [31:0] DONE_INSTR = 32'h0000_0033;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

endpackage

// File: rtl/cpu_dmem.sv
// Data RAM: asynchronous read, write on rising edge, word index wraps (depth is a power of two).
module dmem #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd_o
);
  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0] RAM [0:DMEM_WORDS-1];
  logic        unused_a;

  assign unused_a = ^{a[31:2+AW], a[1:0]};
  assign rd_o     = RAM[a[2 +: AW]];

  // store port
  always_ff @(posedge clk_i) begin
    if (we_i) RAM[a[2 +: AW]] <= wd;
  end
endmodule

// File: rtl/cpu_imem.sv
// Instruction ROM; contents are loaded from outside, word index wraps (depth is a power of two).
module imem #(
  parameter int IMEM_WORDS = 64
) (
  input  logic [31:0] addr_i,
  output logic [31:0] instr_o
);
  localparam int AW = $clog2(IMEM_WORDS);

  logic [31:0] ROM [0:IMEM_WORDS-1];
  logic        unused_addr;

  assign unused_addr = ^{addr_i[31:2+AW], addr_i[1:0]};
  assign instr_o     = ROM[addr_i[2 +: AW]];
endmodule

// File: rtl/cpu_regfile.sv
// 32x32 register file; x0 is hardwired to zero, x1..x31 cleared by reset.
module regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);
  logic [31:0] rf_q [1:31];

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : rf_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : rf_q[ra2_i];

  // write port; writes to x0 are dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < 32; i++) rf_q[i] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      rf_q[wa_i] <= wd_i;
    end
  end
endmodule

// File: rtl/cpu.sv
// Single-cycle RV32I-subset core: fetch, decode, ALU and writeback all in one clock.
module cpu
  import cpu_pkg::*;
#(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n,
  output logic done
);
  logic [31:0] outPC, pc_d, pc4, instr;
  logic [31:0] rs1_v, rs2_v, rdata, wb_v;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] alu_b, alu_y, dm_a;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic        MemWrite, reg_we, is_sw;
  alu_op_t     alu_op;

  imem #(.IMEM_WORDS(IMEM_WORDS)) IMemory (.addr_i(outPC), .instr_o(instr));

  regfile RegFile (
    .clk_i(clk), .rst_ni(rst_n),
    .ra1_i(instr[19:15]), .ra2_i(instr[24:20]),
    .rd1_o(rs1_v), .rd2_o(rs2_v),
    .we_i(reg_we & ~done), .wa_i(instr[11:7]), .wd_i(wb_v)
  );

  dmem #(.DMEM_WORDS(DMEM_WORDS)) DataMemory (
    .clk_i(clk), .we_i(MemWrite), .a(dm_a), .wd(rs2_v), .rd_o(rdata)
  );

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign done   = (instr == DONE_INSTR);
  assign pc4    = outPC + 32'd4;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};

  assign alu_b    = (opcode == OP_R) ? rs2_v : imm_i;
  assign dm_a     = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign MemWrite = is_sw & ~done;

  // ALU
  always_comb begin
    alu_y = rs1_v + alu_b;
    case (alu_op)
      ALU_SUB:  alu_y = rs1_v - alu_b;
      ALU_AND:  alu_y = rs1_v & alu_b;
      ALU_OR:   alu_y = rs1_v | alu_b;
      ALU_XOR:  alu_y = rs1_v ^ alu_b;
      ALU_SLT:  alu_y = {31'd0, $signed(rs1_v) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'd0, rs1_v < alu_b};
      ALU_SLL:  alu_y = rs1_v << alu_b[4:0];
      ALU_SRL:  alu_y = rs1_v >> alu_b[4:0];
      ALU_SRA:  alu_y = $signed(rs1_v) >>> alu_b[4:0];
      default:  alu_y = rs1_v + alu_b;
    endcase
  end

  // decoder: ALU op, writeback select, store enable and next PC; anything unrecognised is a NOP
  always_comb begin
    alu_op = ALU_ADD;
    reg_we = 1'b0;
    is_sw  = 1'b0;
    wb_v   = alu_y;
    pc_d   = pc4;
    case (opcode)
      OP_R, OP_I: begin
        reg_we = 1'b1;
        case (f3)
          3'b000: if (opcode == OP_R && f7 == 7'h20) alu_op = ALU_SUB;
                  else if (opcode == OP_R && f7 != 7'h00) reg_we = 1'b0;
          3'b001: begin alu_op = ALU_SLL; reg_we = (f7 == 7'h00); end
          3'b010: begin alu_op = ALU_SLT;  reg_we = (opcode == OP_I) || (f7 == 7'h00); end
          3'b011: begin alu_op = ALU_SLTU; reg_we = (opcode == OP_I) || (f7 == 7'h00); end
          3'b100: begin alu_op = ALU_XOR;  reg_we = (opcode == OP_I) || (f7 == 7'h00); end
          3'b101: begin
            alu_op = (f7 == 7'h20) ? ALU_SRA : ALU_SRL;
            reg_we = (f7 == 7'h00) || (f7 == 7'h20);
          end
          3'b110: begin alu_op = ALU_OR;   reg_we = (opcode == OP_I) || (f7 == 7'h00); end
          default: begin alu_op = ALU_AND; reg_we = (opcode == OP_I) || (f7 == 7'h00); end
        endcase
      end
      OP_LOAD:  if (f3 == 3'b010) begin reg_we = 1'b1; wb_v = rdata; end
      OP_STORE: is_sw = (f3 == 3'b010);
      OP_BRANCH: begin
        if ((f3 == 3'b000 && rs1_v == rs2_v) || (f3 == 3'b001 && rs1_v != rs2_v))
          pc_d = outPC + imm_b;
      end
      OP_JAL: begin reg_we = 1'b1; wb_v = pc4; pc_d = outPC + imm_j; end
      OP_JALR: if (f3 == 3'b000) begin
        reg_we = 1'b1;
        wb_v   = pc4;
        pc_d   = (rs1_v + imm_i) & ~32'd1;
      end
      OP_LUI:   begin reg_we = 1'b1; wb_v = imm_u; end
      OP_AUIPC: begin reg_we = 1'b1; wb_v = outPC + imm_u; end
      default: ;
    endcase
  end

  // PC register; holds once the end marker is fetched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     outPC <= RESET_PC;
    else if (!done) outPC <= pc_d;
  end
endmodule

// File: tb/tb_cpu.sv
// Directed-program bench for the single-cycle core.
module tb_cpu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done;

  int n_cmp = 0;
  int n_bad = 0;
  int mw_cnt = 0;
  logic [31:0] mw_a, mw_wd;

  cpu DUT (.clk(clk), .rst_n(rst_n), .done(done));

  always #5 clk = ~clk;

  // record every store the core issues
  always @(negedge clk) begin
    if (DUT.MemWrite) begin
      mw_cnt++;
      mw_a  = DUT.DataMemory.a;
      mw_wd = DUT.DataMemory.wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // hold reset, fill ROM with end markers and RAM with zeros
  task automatic start_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) begin
      DUT.IMemory.ROM[i]    = 32'h0000_0033;
      DUT.DataMemory.RAM[i] = 32'h0;
    end
    mw_cnt = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [31:0] trace [4];

    // 1: immediate end marker
    start_reset();
    #1;
    chk("rst_pc", DUT.outPC, 32'h0);
    chk("rst_done", {31'd0, done}, 32'd1);
    chk("rst_x1", DUT.RegFile.rf_q[1], 32'h0);
    release_reset();
    repeat (3) @(negedge clk);
    chk("t1_pc", DUT.outPC, 32'h0);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_mw", mw_cnt, 32'd0);

    // 2: addi/addi/add/sw
    start_reset();
    DUT.IMemory.ROM[0] = 32'h0050_0093;
    DUT.IMemory.ROM[1] = 32'h0070_0113;
    DUT.IMemory.ROM[2] = 32'h0020_81B3;
    DUT.IMemory.ROM[3] = 32'h0030_2423;
    release_reset();
    run_to_done("t2");
    chk("t2_mw", mw_cnt, 32'd1);
    chk("t2_a", mw_a, 32'd8);
    chk("t2_wd", mw_wd, 32'd12);
    chk("t2_ram2", DUT.DataMemory.RAM[2], 32'd12);
    chk("t2_pc", DUT.outPC, 32'h10);
    chk("t2_x3", DUT.RegFile.rf_q[3], 32'd12);

    // 3: lw / sub / sw
    start_reset();
    DUT.DataMemory.RAM[1] = 32'hFFFF_FFF0;
    DUT.IMemory.ROM[0] = 32'h0040_2203;
    DUT.IMemory.ROM[1] = 32'h4040_02B3;
    DUT.IMemory.ROM[2] = 32'h0050_2023;
    release_reset();
    run_to_done("t3");
    chk("t3_x4", DUT.RegFile.rf_q[4], 32'hFFFF_FFF0);
    chk("t3_ram0", DUT.DataMemory.RAM[0], 32'h10);

    // 4: beq taken over a store, bne not taken
    start_reset();
    DUT.IMemory.ROM[0] = 32'h0000_0463;
    DUT.IMemory.ROM[1] = 32'h0000_2023;
    DUT.IMemory.ROM[2] = 32'h0000_1463;
    DUT.IMemory.ROM[3] = 32'h0010_0313;
    trace = '{32'h0, 32'h8, 32'hC, 32'h10};
    release_reset();
    chk("t4_pc0", DUT.outPC, trace[0]);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t4_pc%0d", k), DUT.outPC, trace[k]);
    end
    run_to_done("t4");
    chk("t4_mw", mw_cnt, 32'd0);
    chk("t4_x6", DUT.RegFile.rf_q[6], 32'd1);

    // 5: jal then jalr back
    start_reset();
    DUT.IMemory.ROM[0] = 32'h00C0_00EF;
    DUT.IMemory.ROM[3] = 32'h0000_8067;
    trace = '{32'h0, 32'hC, 32'h4, 32'h4};
    release_reset();
    chk("t5_pc0", DUT.outPC, trace[0]);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t5_pc%0d", k), DUT.outPC, trace[k]);
    end
    chk("t5_x1", DUT.RegFile.rf_q[1], 32'd4);
    chk("t5_done", {31'd0, done}, 32'd1);

    // 6: lui / srai / slt / sltu / auipc
    start_reset();
    DUT.IMemory.ROM[0] = 32'h8000_03B7;
    DUT.IMemory.ROM[1] = 32'h4043_D413;
    DUT.IMemory.ROM[2] = 32'h0003_A4B3;
    DUT.IMemory.ROM[3] = 32'h0003_B533;
    DUT.IMemory.ROM[4] = 32'h0000_1597;
    release_reset();
    run_to_done("t6");
    chk("t6_x7", DUT.RegFile.rf_q[7], 32'h8000_0000);
    chk("t6_x8", DUT.RegFile.rf_q[8], 32'hF800_0000);
    chk("t6_x9", DUT.RegFile.rf_q[9], 32'd1);
    chk("t6_x10", DUT.RegFile.rf_q[10], 32'd0);
    chk("t6_x11", DUT.RegFile.rf_q[11], 32'h0000_1010);
    chk("t6_pc", DUT.outPC, 32'h14);

    // 7: asynchronous reset in the middle of the program
    start_reset();
    DUT.IMemory.ROM[0] = 32'h0050_0093;
    DUT.IMemory.ROM[1] = 32'h0070_0113;
    DUT.IMemory.ROM[2] = 32'h0020_81B3;
    DUT.IMemory.ROM[3] = 32'h0030_2423;
    release_reset();
    repeat (2) @(negedge clk);
    chk("t7_pc_mid", DUT.outPC, 32'h8);
    chk("t7_x1_mid", DUT.RegFile.rf_q[1], 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_pc_rst", DUT.outPC, 32'h0);
    chk("t7_x1_rst", DUT.RegFile.rf_q[1], 32'h0);
    chk("t7_x2_rst", DUT.RegFile.rf_q[2], 32'h0);
    release_reset();
    run_to_done("t7");
    chk("t7_ram2", DUT.DataMemory.RAM[2], 32'd12);
    chk("t7_mw", mw_cnt, 32'd1);
    chk("t7_pc", DUT.outPC, 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
